// File: rtl/ex_muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit, radix-2, one quotient/product bit per cycle.
// Latency: accept at edge E, result valid at edge E+XLEN+2 (special divide cases at E+2).
// Backpressure: op_ready only in IDLE; result held in DONE until res_ready; busy stalls the pipe.
module ex_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] op_tag,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [2:0]          funct3;
  logic [TAG_W-1:0]    tag;
  logic [XLEN-1:0]     dvsr;     // multiplicand for MUL*, divisor magnitude for DIV*/REM*
  logic [2*XLEN-1:0]   acc;      // MUL*: {partial sum, multiplier}; DIV*: {remainder, quotient}
  logic                neg;      // negate the selected result in FIX
  logic [CW-1:0]       counter;

  // Decode of the incoming op: signedness, magnitudes, special divide cases
  logic            in_is_div, in_a_signed, in_b_signed, in_a_neg, in_b_neg;
  logic            in_div_zero, in_ovf, in_special, in_neg;
  logic [XLEN-1:0] in_abs_a, in_abs_b;

  always_comb begin
    in_is_div   = op_funct3[2];
    in_a_signed = op_funct3[2] ? !op_funct3[0] : (op_funct3[1:0] != 2'b11);
    in_b_signed = op_funct3[2] ? !op_funct3[0] : !op_funct3[1];
    in_a_neg    = in_a_signed && op_a[XLEN-1];
    in_b_neg    = in_b_signed && op_b[XLEN-1];
    in_abs_a    = in_a_neg ? (~op_a + 1'b1) : op_a;
    in_abs_b    = in_b_neg ? (~op_b + 1'b1) : op_b;
    in_div_zero = in_is_div && (op_b == '0);
    in_ovf      = in_is_div && !op_funct3[0] && (op_a == MIN_VAL) && (op_b == '1);
    in_special  = in_div_zero || in_ovf;
    // Quotient sign is a^b; remainder follows the dividend; MULHSU follows a only
    if (in_is_div)
      in_neg = op_funct3[1] ? in_a_neg : (in_a_neg ^ in_b_neg);
    else
      in_neg = in_a_neg ^ in_b_neg;
  end

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide)
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] calc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvsr} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, dvsr};
    if (!funct3[2])
      calc_next = {mul_sum, acc[XLEN-1:1]};
    else if (!div_diff[XLEN])
      calc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      calc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Sign fix-up and word selection for the final result
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_word, div_fix, fix_data;

  always_comb begin
    prod_fix = neg ? (~acc + 1'b1) : acc;
    div_word = funct3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_fix  = neg ? (~div_word + 1'b1) : div_word;
    if (funct3[2])
      fix_data = div_fix;
    else if (funct3[1:0] == 2'b00)
      fix_data = prod_fix[XLEN-1:0];
    else
      fix_data = prod_fix[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers; flush drops any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      funct3   <= '0;
      tag      <= '0;
      dvsr     <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      counter  <= '0;
      res_data <= '0;
      res_tag  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            funct3 <= op_funct3;
            tag    <= op_tag;
            if (in_special) begin
              // Preload {remainder, quotient} with the architected special results
              neg   <= 1'b0;
              dvsr  <= '0;
              acc   <= in_div_zero ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, op_a};
              state <= FIX;
            end else begin
              neg     <= in_neg;
              dvsr    <= in_is_div ? in_abs_b : in_abs_a;
              acc     <= {{XLEN{1'b0}}, (in_is_div ? in_abs_a : in_abs_b)};
              counter <= CW'(XLEN);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          acc     <= calc_next;
          counter <= counter - 1'b1;
          if (counter == CW'(1))
            state <= FIX;
        end
        FIX: begin
          res_data <= fix_data;
          res_tag  <= tag;
          state    <= DONE;
        end
        DONE: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit at XLEN=32: directed RV M-extension cases,
// special divide cases, backpressure, flush and reset mid-op, plus random ops.
// Inputs driven and outputs sampled on the falling edge.
module tb_ex_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [2:0]       op_funct3 = '0;
  logic [XLEN-1:0]  op_a = '0;
  logic [XLEN-1:0]  op_b = '0;
  logic [TAG_W-1:0] op_tag = '0;
  logic             busy;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_funct3(op_funct3),
    .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, obs, exp);
    end
  endtask

  // Reference model of the M-extension semantics using 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = sa * sb; w = p; return w[31:0]; end
      3'd1: begin p = sa * sb; w = p; return w[63:32]; end
      3'd2: begin p = sa * ub; w = p; return w[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; w = up; return w[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        p = sa / sb; w = p; return w[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; w = p; return w[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == MINV && b == 32'hFFFF_FFFF));
  endfunction

  // Wait (bounded) for op_ready; returns with the accept edge just behind us
  task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, output bit ok);
    int n;
    op_valid = 1'b1; op_funct3 = f; op_a = a; op_b = b; op_tag = t;
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = op_ready;
    if (!ok) chk("accept_timeout", 64'(op_ready), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Full op: accept, latency check, optional hold under backpressure, pop and compare
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input int hold, input bit chk_lat);
    bit          ok;
    int          k;
    exp_t        e;
    logic [31:0] d0;
    logic [4:0]  t0;
    present(f, a, b, t, ok);
    sb.push_back('{data: model(f, a, b), tag: t});
    if (chk_lat) chk("busy_after_accept", 64'(busy), 64'd1);
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    // k edges after E the state is DONE, so valid is seen by the consumer at edge E+k+1
    if (chk_lat)
      chk("latency", 64'(k + 1), is_special(f, a, b) ? 64'd2 : 64'(XLEN + 2));
    d0 = res_data;
    t0 = res_tag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(d0));
      chk("hold_tag", 64'(res_tag), 64'(t0));
      chk("hold_op_ready", 64'(op_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    res_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("res_valid", 64'(res_valid), 64'd1);
      chk("res_data", 64'(res_data), 64'(e.data));
      chk("res_tag", 64'(res_tag), 64'(e.tag));
    end
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_valid", 64'(res_valid), 64'd0);
    chk("post_op_ready", 64'(op_ready), 64'd1);
  endtask

  initial begin
    bit          ok;
    int          seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);

    // Multiplies
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0, 1'b1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 1'b1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 1'b1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 0, 1'b1);
    run_op(3'd1, MINV, MINV, 5'd5, 0, 1'b1);
    // Divides
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 1'b1);
    run_op(3'd5, 32'd100, 32'd7, 5'd8, 0, 1'b1);
    run_op(3'd7, 32'd100, 32'd7, 5'd9, 0, 1'b1);
    // Special divide cases
    run_op(3'd5, 32'd5, 32'd0, 5'd10, 0, 1'b1);
    run_op(3'd6, 32'd5, 32'd0, 5'd11, 0, 1'b1);
    run_op(3'd4, MINV, 32'hFFFF_FFFF, 5'd12, 0, 1'b1);
    run_op(3'd6, MINV, 32'hFFFF_FFFF, 5'd13, 0, 1'b1);
    run_op(3'd4, 32'd9, 32'd0, 5'd14, 0, 1'b1);
    // Backpressure in DONE
    run_op(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 5, 1'b1);

    // Flush sampled at edge E+10 during a DIV
    present(3'd4, 32'd1000, 32'd3, 5'd16, ok);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_op_ready", 64'(op_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    run_op(3'd4, 32'd1000, 32'hFFFF_FFFD, 5'd17, 0, 1'b1);

    // Presenting an op with flush high must not be accepted
    flush = 1'b1;
    op_valid = 1'b1; op_funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    chk("flush_block_busy", 64'(busy), 64'd0);
    flush = 1'b0;
    op_valid = 1'b0;

    // Reset in the middle of CALC
    present(3'd0, 32'd11, 32'd13, 5'd20, ok);
    repeat (5) @(negedge clk);
    chk("pre_rst_data_nonzero", 64'(res_data != 0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_op_ready", 64'(op_ready), 64'd1);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_res_data", 64'(res_data), 64'd0);
    chk("midrst_res_tag", 64'(res_tag), 64'd0);

    // Random ops with a bias toward corner operands
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: ra = MINV;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, 5'(i), i % 3, 1'b1);
    end

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
